led_pixel_fetcher: RTL

- Downstream consumer of the LED timing generator. Takes the generator's current-pixel coordinates (x, bank, bit-plane) and vsync, and reads packed RGB pixels from a double-buffered frame RAM.
- Drives the six HUB75 colour lines (upper and lower half-panel) with the selected bit-plane bit, registered before the LED clock rises.
- Swaps the front buffer on vsync when the host requests it.

---
 rtl/led_pixel_fetcher_pkg.sv | 37 +++
 rtl/led_pixel_fetcher_buffer_swap_ctl.sv | 33 +++
 rtl/led_pixel_fetcher.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/led_pixel_fetcher_pkg.sv
// Shared widths, FSM encoding and colour-bit selection for the HUB75 pixel fetcher.
// The timing generator uses the same X_W/Y_W/BIT_W so coordinates line up.
package led_pixel_fetcher_pkg;

    localparam int C_LED_CHAIN_LENGTH = 4;
    localparam int C_LED_NBANKS       = 16;
    localparam int C_LED_WIDTH        = 32;
    localparam int C_BPC              = 12;

    localparam int X_W    = $clog2(C_LED_WIDTH * C_LED_CHAIN_LENGTH);
    localparam int Y_W    = $clog2(C_LED_NBANKS);
    localparam int BIT_W  = $clog2(C_BPC);
    localparam int ROW_W  = $clog2(2 * C_LED_NBANKS);
    localparam int ADDR_W = 1 + ROW_W + X_W;
    localparam int WORD_W = 3 * C_BPC;
    localparam int CRD_W  = X_W + Y_W + BIT_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_TOP  = 3'd1,
        ST_RD_BOT  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } fetch_state_e;

    // Returns {R,G,B} bits of one bit-plane; planes beyond C_BPC read as dark.
    function automatic logic [2:0] pick_rgb(input logic [WORD_W-1:0] word,
                                            input logic [BIT_W-1:0]  bit_idx);
        logic [5:0] bi;
        bi = {2'b00, bit_idx};
        if (bit_idx >= BIT_W'(C_BPC)) begin
            return 3'b000;
        end
        return {word[6'(2 * C_BPC) + bi], word[6'(C_BPC) + bi], word[bi]};
    endfunction

endpackage

// File: rtl/led_pixel_fetcher_buffer_swap_ctl.sv
// Front-buffer select: toggles on a registered rising edge of vsync while the host requests a swap.
module buffer_swap_ctl (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic vsync_i,
    input  logic swap_req_i,
    output logic front_buf_o,
    output logic swap_ack_o
);

    logic vsync_q;
    logic front_buf_q;
    logic swap_ack_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vsync_q     <= 1'b0;
            front_buf_q <= 1'b0;
            swap_ack_q  <= 1'b0;
        end else begin
            vsync_q    <= vsync_i;
            swap_ack_q <= 1'b0;
            if (vsync_i && !vsync_q && swap_req_i) begin
                front_buf_q <= ~front_buf_q;
                swap_ack_q  <= 1'b1;
            end
        end
    end

    assign front_buf_o = front_buf_q;
    assign swap_ack_o  = swap_ack_q;

endmodule

// File: rtl/led_pixel_fetcher.sv
// Fetches the top/bottom pixel words for the current LED coordinate from a double-buffered
// frame RAM and registers the selected bit-plane onto the six HUB75 colour lines.
//
//   state   | meaning
//   IDLE    | waiting for a coordinate change, forced refetch or pending request
//   RD_TOP  | read strobe for the upper half-panel word
//   RD_BOT  | read strobe for the lower half-panel word
//   WAIT    | extra RAM latency cycles (unused when latency is 1)
//   CAPTURE | bottom word arrives; all six colour lines update together
module led_pixel_fetcher
    import led_pixel_fetcher_pkg::*;
#(
    parameter int C_MEM_LATENCY = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sys_en,
    input  logic [X_W-1:0]    ctl_cur_x,
    input  logic [Y_W-1:0]    ctl_cur_y,
    input  logic [BIT_W-1:0]  ctl_cur_bit,
    input  logic              ctl_vsync,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_buf,
    output logic              led_r0,
    output logic              led_g0,
    output logic              led_b0,
    output logic              led_r1,
    output logic              led_g1,
    output logic              led_b1,
    output logic              fetch_overrun
);

    fetch_state_e             state_q;
    logic [CRD_W-1:0]         cur_coord;
    logic [CRD_W-1:0]         prev_coord_q;
    logic                     force_fetch_q;
    logic                     pending_q;
    logic                     coord_chg;
    logic                     launch;
    logic [X_W-1:0]           fx_q;
    logic [Y_W-1:0]           fy_q;
    logic [BIT_W-1:0]         fbit_q;
    logic                     fbuf_q;
    logic [ROW_W-1:0]         row_bot;
    logic [1:0]               wait_cnt_q;
    logic [C_MEM_LATENCY-1:0] top_pipe_q;
    logic [WORD_W-1:0]        top_word_q;
    logic [ADDR_W-1:0]        mem_addr_q;
    logic                     mem_rd_en_q;
    logic [5:0]               leds_q;
    logic                     overrun_q;

    buffer_swap_ctl u_swap (
        .clk_i       (sys_clk),
        .rst_n_i     (sys_rst),
        .vsync_i     (ctl_vsync),
        .swap_req_i  (swap_req),
        .front_buf_o (front_buf),
        .swap_ack_o  (swap_ack)
    );

    assign cur_coord = {ctl_cur_x, ctl_cur_y, ctl_cur_bit};
    assign coord_chg = (cur_coord != prev_coord_q);
    assign launch    = sys_en && (coord_chg || force_fetch_q || pending_q);
    assign row_bot   = ROW_W'(fy_q) + ROW_W'(C_LED_NBANKS);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q       <= ST_IDLE;
            prev_coord_q  <= '0;
            force_fetch_q <= 1'b1;
            pending_q     <= 1'b0;
            fx_q          <= '0;
            fy_q          <= '0;
            fbit_q        <= '0;
            fbuf_q        <= 1'b0;
            wait_cnt_q    <= '0;
            top_pipe_q    <= '0;
            top_word_q    <= '0;
            mem_addr_q    <= '0;
            mem_rd_en_q   <= 1'b0;
            leds_q        <= '0;
            overrun_q     <= 1'b0;
        end else begin
            prev_coord_q <= cur_coord;
            overrun_q    <= coord_chg && (state_q != ST_IDLE);
            mem_rd_en_q  <= 1'b0;

            // Tracks when the top word's read data becomes valid, independent of the FSM path.
            top_pipe_q[0] <= (state_q == ST_RD_TOP);
            for (int i = 1; i < C_MEM_LATENCY; i++) begin
                top_pipe_q[i] <= top_pipe_q[i-1];
            end
            if (top_pipe_q[C_MEM_LATENCY-1]) begin
                top_word_q <= mem_rdata;
            end

            if (swap_ack) begin
                force_fetch_q <= 1'b1;
            end
            if (coord_chg && (state_q != ST_IDLE)) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        fx_q          <= ctl_cur_x;
                        fy_q          <= ctl_cur_y;
                        fbit_q        <= ctl_cur_bit;
                        fbuf_q        <= front_buf;
                        mem_addr_q    <= {front_buf, ROW_W'(ctl_cur_y), ctl_cur_x};
                        mem_rd_en_q   <= 1'b1;
                        force_fetch_q <= 1'b0;
                        pending_q     <= 1'b0;
                        state_q       <= ST_RD_TOP;
                    end
                end
                ST_RD_TOP: begin
                    mem_addr_q  <= {fbuf_q, row_bot, fx_q};
                    mem_rd_en_q <= 1'b1;
                    state_q     <= ST_RD_BOT;
                end
                ST_RD_BOT: begin
                    if (C_MEM_LATENCY == 1) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        wait_cnt_q <= 2'(C_MEM_LATENCY - 2);
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                ST_CAPTURE: begin
                    leds_q  <= {pick_rgb(top_word_q, fbit_q), pick_rgb(mem_rdata, fbit_q)};
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_rd_en     = mem_rd_en_q;
    assign fetch_overrun = overrun_q;
    assign {led_r0, led_g0, led_b0, led_r1, led_g1, led_b1} = leds_q;

endmodule
